// File: rtl/timer_mmio_responder.sv
// rtl/timer_mmio_responder.sv - memory-mapped prescaled timer with compare, overflow and irq
// Define TIMER_CAPTURE_EN to add the Capture input, CAPTURE register (offset 4) and STATUS.cap.
module timer_mmio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic        Wr,
  input  logic [31:0] Datain,
`ifdef TIMER_CAPTURE_EN
  input  logic        Capture,
`endif
  output logic [31:0] Dataout,
  output logic        Hit,
  output logic        Irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic        ar_q, ar_d;
  logic        ie_q, ie_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic        ovf_q, ovf_d;
  logic [31:0] dout_q, dout_d;
  logic        hit_q;

  logic        sel;
  logic [2:0]  off;
  logic        wr_ctrl, wr_count, wr_cmp, wr_status;
  logic        en, tick;
  logic [31:0] rdata;
  logic        cap_flag;
  logic [31:0] cap_val;
  logic        addr_unused;

  assign sel         = (Address[31:5] == BASE_ADDR[31:5]);
  assign off         = Address[4:2];
  assign addr_unused = ^Address[1:0];
  assign wr_ctrl     = sel & Wr & (off == 3'd0);
  assign wr_count    = sel & Wr & (off == 3'd1);
  assign wr_cmp      = sel & Wr & (off == 3'd2);
  assign wr_status   = sel & Wr & (off == 3'd3);
  assign en          = (state_q == RUN);
  assign tick        = en & (pcnt_q == PMAX);

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    cmp_d   = cmp_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    match_d = match_q;
    ovf_d   = ovf_q;

    if (wr_ctrl) begin
      state_d = Datain[0] ? RUN : IDLE;
      ar_d    = Datain[1];
      ie_d    = Datain[2];
    end
    if (wr_cmp) cmp_d = Datain;
    if (wr_status) begin
      match_d = match_q & ~Datain[0];
      ovf_d   = ovf_q & ~Datain[1];
    end

    if (!en || wr_count || tick) pcnt_d = 16'd0;
    else                         pcnt_d = pcnt_q + 16'd1;

    // A COUNT write discards a coincident tick; flag sets override W1C.
    if (wr_count) begin
      count_d = Datain;
    end else if (tick) begin
      count_d = ((count_q == cmp_q) && ar_q) ? 32'd0 : count_q + 32'd1;
      if (count_q == cmp_q) match_d = 1'b1;
      if (&count_q)         ovf_d   = 1'b1;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic        cap_prev_q;
  logic        cap_q, cap_d;
  logic [31:0] capture_q, capture_d;

  always_comb begin
    cap_d     = cap_q;
    capture_d = capture_q;
    if (wr_status) cap_d = cap_q & ~Datain[2];
    if (Capture && !cap_prev_q) begin
      cap_d     = 1'b1;
      capture_d = count_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cap_prev_q <= 1'b0;
      cap_q      <= 1'b0;
      capture_q  <= 32'd0;
    end else begin
      cap_prev_q <= Capture;
      cap_q      <= cap_d;
      capture_q  <= capture_d;
    end
  end

  assign cap_flag = cap_q;
  assign cap_val  = capture_q;
`else
  assign cap_flag = 1'b0;
  assign cap_val  = 32'd0;
`endif

  always_comb begin
    rdata = 32'd0;
    case (off)
      3'd0:    rdata = {29'd0, ie_q, ar_q, en};
      3'd1:    rdata = count_q;
      3'd2:    rdata = cmp_q;
      3'd3:    rdata = {29'd0, cap_flag, ovf_q, match_q};
      3'd4:    rdata = cap_val;
      default: rdata = 32'd0;
    endcase
    dout_d = (sel && !Wr) ? rdata : 32'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      pcnt_q  <= 16'd0;
      count_q <= 32'd0;
      cmp_q   <= 32'd0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= 32'd0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      hit_q   <= sel;
    end
  end

  assign Dataout = dout_q;
  assign Hit     = hit_q;
  assign Irq     = ie_q & (match_q | ovf_q | cap_flag);

endmodule

// File: tb/tb_timer_mmio_responder.sv
// tb/tb_timer_mmio_responder.sv - vector table, corner sequences and random run against a reference model
module tb_timer_mmio_responder;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          PRESC = 4;
`ifdef TIMER_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Address;
  logic        Wr;
  logic [31:0] Datain;
`ifdef TIMER_CAPTURE_EN
  logic        Capture;
`endif
  logic [31:0] Dataout;
  logic        Hit;
  logic        Irq;

  timer_mmio_responder #(.BASE_ADDR(BASE), .PRESCALE(PRESC)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Address (Address),
    .Wr      (Wr),
    .Datain  (Datain),
`ifdef TIMER_CAPTURE_EN
    .Capture (Capture),
`endif
    .Dataout (Dataout),
    .Hit     (Hit),
    .Irq     (Irq)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register contents plus cycles elapsed since the prescaler last restarted.
  logic        m_run, m_ar, m_ie, m_match, m_ovf, m_cap, m_cprev;
  logic [31:0] m_cnt, m_cmp, m_capv, m_dout;
  logic        m_hit;
  int          m_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0:       return {29'd0, m_ie, m_ar, m_run};
      1:       return m_cnt;
      2:       return m_cmp;
      3:       return {29'd0, m_cap, m_ovf, m_match};
      4:       return CAP_EN ? m_capv : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic c);
    logic        sel, tick, wc, hit_cmp;
    int          off;
    logic [31:0] old_cnt;
    if (rst) begin
      m_run = 0; m_ar = 0; m_ie = 0; m_match = 0; m_ovf = 0; m_cap = 0; m_cprev = 0;
      m_cnt = 0; m_cmp = 0; m_capv = 0; m_dout = 0; m_hit = 0; m_phase = 0;
      return;
    end
    sel     = ((a >> 5) == (BASE >> 5));
    off     = int'(a[4:2]);
    m_dout  = (sel && !w) ? model_read(off) : 32'd0;
    m_hit   = sel;
    tick    = m_run && ((m_phase + 1) % PRESC == 0);
    wc      = sel && w && off == 1;
    old_cnt = m_cnt;
    hit_cmp = (old_cnt == m_cmp);
    if (sel && w && off == 3) begin
      if (d[0]) m_match = 0;
      if (d[1]) m_ovf = 0;
      if (d[2]) m_cap = 0;
    end
    if (tick && !wc) begin
      if (hit_cmp) m_match = 1;
      if (old_cnt == 32'hFFFF_FFFF) m_ovf = 1;
      m_cnt = (hit_cmp && m_ar) ? 32'd0 : old_cnt + 32'd1;
    end
    if (wc) m_cnt = d;
    if (CAP_EN && c && !m_cprev) begin
      m_capv = old_cnt;
      m_cap  = 1;
    end
    m_cprev = c;
    m_phase = (!m_run || wc || tick) ? 0 : m_phase + 1;
    if (sel && w && off == 2) m_cmp = d;
    if (sel && w && off == 0) begin
      m_run = d[0]; m_ar = d[1]; m_ie = d[2];
    end
  endtask

  task automatic cycle(input logic [31:0] a, input logic w, input logic [31:0] d, input logic c);
    Address = a; Wr = w; Datain = d;
`ifdef TIMER_CAPTURE_EN
    Capture = c;
`endif
    @(posedge Clk);
    model_step(Reset, a, w, d, c);
    #1;
    check("model_dout", Dataout, m_dout);
    check_bit("model_hit", Hit, m_hit);
    check_bit("model_irq", Irq, m_ie & (m_match | m_ovf | m_cap));
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    cycle(BASE + 32'(off * 4), 1'b1, d, 1'b0);
  endtask

  task automatic rd(input int off);
    cycle(BASE + 32'(off * 4), 1'b0, 32'd0, 1'b0);
  endtask

  task automatic nop();
    cycle(32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    nop();
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [31:0] dout;
    logic        hit;
    logic        irq;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [31:0] a, d;
    logic        w, c;
    Reset = 1'b1; Address = 32'd0; Wr = 1'b0; Datain = 32'd0;
`ifdef TIMER_CAPTURE_EN
    Capture = 1'b0;
`endif
    nop();
    check("reset_dout", Dataout, 32'd0);
    check_bit("reset_hit", Hit, 1'b0);
    check_bit("reset_irq", Irq, 1'b0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) tbl.push_back('{BASE + 32'(i * 4), 1'b0, 32'd0, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{32'h0000_0420, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0});
    tbl.push_back('{32'h0000_0424, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0});
    tbl.push_back('{32'h0000_0420, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0});
    tbl.push_back('{BASE + 32'd8, 1'b1, 32'h55, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{BASE + 32'd8, 1'b0, 32'd0, 32'h55, 1'b1, 1'b0});
    tbl.push_back('{BASE, 1'b1, 32'hFFFF_FFF6, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{BASE + 32'd3, 1'b0, 32'd0, 32'd6, 1'b1, 1'b0});
    tbl.push_back('{BASE + 32'd4, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{BASE + 32'd12, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{BASE + 32'd12, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{BASE + 32'd20, 1'b1, 32'h1234, 32'd0, 1'b1, 1'b0});
    tbl.push_back('{BASE + 32'd20, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0});
    foreach (tbl[i]) begin
      cycle(tbl[i].a, tbl[i].w, tbl[i].d, 1'b0);
      check("vec_dout", Dataout, tbl[i].dout);
      check_bit("vec_hit", Hit, tbl[i].hit);
      check_bit("vec_irq", Irq, tbl[i].irq);
    end

    // Compare match lands 16 clocks after enabling with COMPARE=3.
    do_reset();
    wr(1, 32'd0); wr(2, 32'd3); wr(0, 32'd5);
    for (int i = 1; i <= 16; i++) begin
      nop();
      check_bit("match_irq_timing", Irq, i == 16);
    end
    rd(1); check("count_after_match", Dataout, 32'd4);
    rd(3); check("status_after_match", Dataout, 32'd1);

    // Autoreload cycle 0,1,2 and W1C colliding with a match tick.
    do_reset();
    wr(2, 32'd2); wr(0, 32'd7);
    for (int i = 1; i <= 24; i++) begin
      rd(1);
      check("autoreload_seq", Dataout, 32'(((i - 1) / 4) % 3));
    end
    wr(3, 32'd1); check_bit("w1c_clears_irq", Irq, 1'b0);
    for (int i = 26; i <= 35; i++) nop();
    wr(3, 32'd1); check_bit("w1c_on_match_tick_irq", Irq, 1'b1);
    rd(3); check("w1c_on_match_tick_status", Dataout, 32'd1);

    // Wrap from all-ones sets ovf only.
    do_reset();
    wr(1, 32'hFFFF_FFFE); wr(2, 32'd5); wr(0, 32'd1);
    for (int i = 1; i <= 9; i++) nop();
    rd(3); check("wrap_status", Dataout, 32'd2);
    rd(1); check("wrap_count", Dataout, 32'd0);

    // COUNT write on a tick edge wins; next step after a full prescale period.
    do_reset();
    wr(0, 32'd1);
    for (int i = 1; i <= 3; i++) nop();
    wr(1, 32'd100);
    for (int i = 5; i <= 9; i++) begin
      rd(1);
      check("count_write_collision", Dataout, (i == 9) ? 32'd101 : 32'd100);
    end

`ifdef TIMER_CAPTURE_EN
    do_reset();
    wr(1, 32'd7);
    cycle(32'd0, 1'b0, 32'd0, 1'b1);
    nop();
    rd(4); check("capture_value", Dataout, 32'd7);
    rd(3); check("capture_status", Dataout, 32'd4);
`endif

    do_reset();
    c = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(0, 99) < 8) a = 32'h0000_0420 + 32'($urandom_range(0, 7) * 4);
      else a = BASE + 32'($urandom_range(0, 7) * 4);
      a[1:0] = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 3) == 0);
      d = $urandom;
      case (a[4:2])
        3'd0: d[0] = ($urandom_range(0, 4) != 0);
        3'd1: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : 32'($urandom_range(0, 12));
        3'd2: d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) c = ~c;
      cycle(a, w, d, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_mmio_responder.md
Name: timer_mmio_responder

Overview:
- Memory-mapped timer peripheral that answers the CPU's data-memory bus (Address/Wr/Datain/Dataout) at a fixed address window, alongside the main memory.
- Provides a prescaled 32-bit up-counter, a compare match, an overflow flag and an interrupt request.
- Read latency equals the main memory's (one registered cycle), so the existing multicycle state timing applies unchanged.

Parameters:
- BASE_ADDR, 32'h0000_0400, word-aligned base of the 32-byte register window.
- PRESCALE, 4, clock cycles per count tick when enabled; legal range 1..65535.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Address  input  32  byte address from the CPU address mux; bits [1:0] ignored.
- Wr  input  1  write strobe; sampled on the same edge as Address and Datain.
- Datain  input  32  write data from the store path.
- Dataout  output  32  registered read data; 0 when not selected.
- Hit  output  1  registered; high the cycle after an access falls in the window.
- Irq  output  1  level interrupt request = STATUS.match & CTRL.ie, or STATUS.ovf & CTRL.ie.

Behaviour:
- Decode:
  - Selected when Address[31:5] == BASE_ADDR[31:5].
  - Offset = Address[4:2].
  - Registers at offsets 0..3; offsets 4..7 read 0 and ignore writes, except as defined under Optional Feature.
- Register map:
  - Off 0 CTRL, R/W, bits [2:0]:
    - bit0 en
    - bit1 autoreload
    - bit2 ie
    - other bits read 0.
  - Off 1 COUNT, R/W, 32 bits.
  - Off 2 COMPARE, R/W, 32 bits.
  - Off 3 STATUS, bits [1:0]:
    - bit0 match, bit1 ovf.
    - Write-1-to-clear; writing 0 has no effect.
- Reads:
  - Dataout is updated every edge: the selected register's value, or 0 if not selected or Wr=1.
  - Returned value is the pre-edge value, so a read and a tick on the same edge return the old COUNT.
- Prescaler:
  - Internal counter pcnt runs 0..PRESCALE-1 while en=1.
  - A tick occurs on the edge where pcnt == PRESCALE-1; pcnt then returns to 0.
  - pcnt is forced to 0 while en=0 and on any COUNT write.
- Count on tick:
  - If COUNT == COMPARE: set match; next COUNT = 0 if autoreload, else COUNT+1.
  - If COUNT == 32'hFFFF_FFFF: COUNT wraps to 0 and ovf is set. match is also set if COMPARE equals all-ones.
  - Otherwise COUNT+1.
- Simultaneous events:
  - CPU write to COUNT on a tick edge: the write wins and the tick is discarded.
  - Write-1-clear of a flag on the same edge it is set by a tick: set wins.
  - Write to COMPARE on a tick edge: the comparison uses the old COMPARE.
- State machine: the block is an IDLE/RUN pair driven by CTRL.en.
  - IDLE → RUN on a write setting en.
  - RUN → IDLE on a write clearing en.
  - COUNT holds in IDLE.
- Reset:
  - All registers, pcnt and flags reset to 0.
  - Dataout = 0, Hit = 0, Irq = 0.
  - Reset mid-count aborts the count immediately, with no pending tick.
- Irq is combinational from registered state; no glitch source other than register outputs.

Optional Feature:
- Macro TIMER_CAPTURE_EN.
- When defined:
  - Adds input port Capture (1 bit).
  - Adds CAPTURE register at offset 4 (read-only) and STATUS bit2 cap (W1C).
  - A rising edge of Capture is detected via a one-flop delay. On that edge, CAPTURE <= COUNT (the pre-tick value) and cap is set.
  - Irq additionally ORs cap & ie.
  - A capture edge coinciding with a COUNT write captures the pre-write value.
- When undefined:
  - No Capture port.
  - Offset 4 reads 0.
  - STATUS bit2 reads 0.

Test Plan:
- Reset, then read all offsets 0..7 at BASE_ADDR → Dataout = 0 for each, Hit=1 one cycle after each access, Irq=0.
- PRESCALE=4: write COUNT=0 and COMPARE=3, then CTRL=3'b101 → match set on the 16th clock after the CTRL write edge; Irq=1; with autoreload=0, COUNT reads 4 four cycles later.
- Autoreload: CTRL=3'b111, COMPARE=2 → COUNT sequence 0,1,2,0,1,2 at one step per 4 clocks; write STATUS=1 → match and Irq clear unless a match tick lands on that edge.
- Wrap: COUNT=32'hFFFF_FFFE, COMPARE=5, en=1 → after 2 ticks COUNT=0, ovf=1, match=0.
- Collision: write COUNT=100 on the exact tick edge → COUNT reads 100, then 101 exactly PRESCALE cycles later; W1C of match on a match-tick edge → match stays 1.
- Address 32'h0000_0420 (outside the window) read and write → no register change, Dataout=0, Hit=0. With TIMER_CAPTURE_EN, a Capture pulse at COUNT=7 → offset 4 reads 7 and STATUS=3'b100.
